// File: rtl/td4_prog_loader_if.sv
// Load-stream and fetch-port bundle between a program source / TD4 cpu and the
// writable program memory in td4_prog_loader.
interface td4_prog_loader_if #(
    parameter int AW = 4,
    parameter int DW = 8
) ();
    logic [AW-1:0] address;
    logic [DW-1:0] instr;
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          cpu_n_reset;
    logic          busy;
    logic          loaded;
    logic          error;

    modport master (
        output address, ld_start, ld_valid, ld_data,
        input  instr, ld_ready, cpu_n_reset, busy, loaded, error
    );

    modport slave (
        input  address, ld_start, ld_valid, ld_data,
        output instr, ld_ready, cpu_n_reset, busy, loaded, error
    );
endinterface

// File: rtl/td4_prog_loader.sv
// Writable 16x8 program memory for the TD4 cpu: byte-stream loader with optional
// checksum, holding the cpu in reset until a verified image is in place.
module td4_prog_loader #(
    parameter int AW          = 4,
    parameter int DW          = 8,
    parameter int CHECKSUM_EN = 1,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    td4_prog_loader_if.slave   bus
);
    localparam int WORDS = 2 ** AW;
    localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHK,
        RELEASE,
        RUN,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem_q [WORDS];
    logic [AW-1:0] wp_q, wp_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          we;
    logic          xfer;
    logic          cpu_n_reset_q;
    logic          ld_ready_q;
    logic          busy_q;
    logic          loaded_q;
    logic          error_q;

    assign xfer = bus.ld_valid & ld_ready_q;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        sum_d   = sum_q;
        hold_d  = hold_q;
        we      = 1'b0;
        // A restart wins over everything, including a byte offered in the same cycle.
        if (bus.ld_start) begin
            state_d = LOAD;
            wp_d    = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (xfer) begin
                        we    = 1'b1;
                        sum_d = sum_q + bus.ld_data;
                        wp_d  = wp_q + 1'b1;
                        if (&wp_q) begin
                            state_d = (CHECKSUM_EN != 0) ? CHK : RELEASE;
                            hold_d  = HW'(HOLD_CYCLES - 1);
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        state_d = (bus.ld_data == sum_q) ? RELEASE : ERR;
                        hold_d  = HW'(HOLD_CYCLES - 1);
                    end
                end
                RELEASE: begin
                    if (hold_q == '0) begin
                        state_d = RUN;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wp_q          <= '0;
            sum_q         <= '0;
            hold_q        <= '0;
            cpu_n_reset_q <= 1'b0;
            ld_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            loaded_q      <= 1'b0;
            error_q       <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            sum_q   <= sum_d;
            hold_q  <= hold_d;
            if (we) begin
                mem_q[wp_q] <= bus.ld_data;
            end
            // Status flags are decoded from the next state so they change on the same edge.
            cpu_n_reset_q <= (state_d == RUN);
            ld_ready_q    <= (state_d == LOAD) || (state_d == CHK);
            busy_q        <= (state_d == LOAD) || (state_d == RELEASE);
            loaded_q      <= (state_d == RUN);
            error_q       <= (state_d == ERR);
        end
    end

    assign bus.instr       = mem_q[bus.address];
    assign bus.ld_ready    = ld_ready_q;
    assign bus.cpu_n_reset = cpu_n_reset_q;
    assign bus.busy        = busy_q;
    assign bus.loaded      = loaded_q;
    assign bus.error       = error_q;
endmodule

// File: tb/tb_td4_prog_loader.sv
// Bench for td4_prog_loader: directed loads, a vector table and a randomized run
// against a byte-level behavioural model of the loader.
module tb_td4_prog_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    td4_prog_loader_if #(.AW(4), .DW(8)) if1 ();
    td4_prog_loader_if #(.AW(4), .DW(8)) if0 ();

    td4_prog_loader #(.AW(4), .DW(8), .CHECKSUM_EN(1), .HOLD_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .bus(if1)
    );
    td4_prog_loader #(.AW(4), .DW(8), .CHECKSUM_EN(0), .HOLD_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model of the checksum-enabled instance.
    localparam int P_IDLE = 0, P_LOADING = 1, P_AWAIT = 2, P_RELEASING = 3, P_RUNNING = 4, P_ERROR = 5;
    localparam int HOLD = 2;
    int         m_phase;
    int         m_n;
    int         m_rel;
    logic [7:0] m_sum;
    logic [7:0] m_mem [16];

    logic [7:0] img [16];

    typedef struct {
        bit         st;
        bit         v;
        logic [7:0] d;
        bit         e_rdy;
        bit         e_busy;
        bit         e_ld;
        bit         e_err;
        bit         e_nrst;
    } vec_t;
    vec_t tbl [6];

    function automatic void m_reset();
        m_phase = P_IDLE;
        m_n     = 0;
        m_rel   = 0;
        m_sum   = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    endfunction

    function automatic void m_edge(bit st, bit v, logic [7:0] d);
        bit rdy;
        rdy = (m_phase == P_LOADING) || (m_phase == P_AWAIT);
        if (st) begin
            m_phase = P_LOADING;
            m_n     = 0;
            m_sum   = 8'h00;
        end else if (v && rdy) begin
            if (m_phase == P_LOADING) begin
                m_mem[m_n] = d;
                m_sum      = m_sum + d;
                m_n        = m_n + 1;
                if (m_n == 16) begin
                    m_n     = 0;
                    m_phase = P_AWAIT;
                end
            end else begin
                m_phase = (d == m_sum) ? P_RELEASING : P_ERROR;
                m_rel   = 0;
            end
        end else if (m_phase == P_RELEASING) begin
            m_rel = m_rel + 1;
            if (m_rel == HOLD) m_phase = P_RUNNING;
        end
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp_model();
        check("ready",  32'(if1.ld_ready),    32'((m_phase == P_LOADING) || (m_phase == P_AWAIT)));
        check("busy",   32'(if1.busy),        32'((m_phase == P_LOADING) || (m_phase == P_RELEASING)));
        check("loaded", 32'(if1.loaded),      32'(m_phase == P_RUNNING));
        check("error",  32'(if1.error),       32'(m_phase == P_ERROR));
        check("nrst",   32'(if1.cpu_n_reset), 32'(m_phase == P_RUNNING));
        check("instr",  32'(if1.instr),       32'(m_mem[if1.address]));
    endtask

    task automatic cyc(input bit st, input bit v, input logic [7:0] d, input logic [3:0] a);
        if1.ld_start = st;
        if1.ld_valid = v;
        if1.ld_data  = d;
        if1.address  = a;
        @(posedge clk);
        #1;
        m_edge(st, v, d);
        cmp_model();
    endtask

    task automatic do_reset();
        if1.ld_start = 1'b0;
        if1.ld_valid = 1'b0;
        if0.ld_start = 1'b0;
        if0.ld_valid = 1'b0;
        reset = 1'b1;
        #2;
        m_reset();
        check("rst_ready", 32'(if1.ld_ready),    32'(0));
        check("rst_busy",  32'(if1.busy),        32'(0));
        check("rst_nrst",  32'(if1.cpu_n_reset), 32'(0));
        check("rst_instr", 32'(if1.instr),       32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic stream(input logic [7:0] ck);
        for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, img[k], 4'(k));
        cyc(1'b0, 1'b1, ck, 4'd0);
    endtask

    initial begin
        logic [7:0] ck;
        int         k;
        int         cyc_used;
        bit         st;
        bit         v;
        logic [7:0] d;

        reset = 1'b1;
        if1.ld_start = 0; if1.ld_valid = 0; if1.ld_data = 0; if1.address = 0;
        if0.ld_start = 0; if0.ld_valid = 0; if0.ld_data = 0; if0.address = 0;
        m_reset();
        for (int a = 0; a < 16; a++) begin
            if1.address = 4'(a);
            @(posedge clk);
            #1;
            check("reset_instr", 32'(if1.instr), 32'(0));
        end
        check("reset_ready",  32'(if1.ld_ready),    32'(0));
        check("reset_busy",   32'(if1.busy),        32'(0));
        check("reset_loaded", 32'(if1.loaded),      32'(0));
        check("reset_error",  32'(if1.error),       32'(0));
        check("reset_nrst",   32'(if1.cpu_n_reset), 32'(0));
        reset = 1'b0;

        // Test 1: reference image with correct checksum.
        img = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        check("t1_start_busy", 32'(if1.busy), 32'(1));
        check("t1_start_rdy",  32'(if1.ld_ready), 32'(1));
        stream(8'h09);
        check("t1_rel_busy", 32'(if1.busy), 32'(1));
        check("t1_rel_nrst", 32'(if1.cpu_n_reset), 32'(0));
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        check("t1_rel2_loaded", 32'(if1.loaded), 32'(0));
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        check("t1_loaded", 32'(if1.loaded), 32'(1));
        check("t1_nrst",   32'(if1.cpu_n_reset), 32'(1));
        check("t1_instr0", 32'(if1.instr), 32'(8'hB7));

        // Vector table: RUN ignores bytes, ld_start always restarts.
        tbl[0] = '{0, 1, 8'h55, 0, 0, 1, 0, 1};
        tbl[1] = '{0, 0, 8'h00, 0, 0, 1, 0, 1};
        tbl[2] = '{1, 1, 8'hAA, 1, 1, 0, 0, 0};
        tbl[3] = '{0, 1, 8'h01, 1, 1, 0, 0, 0};
        tbl[4] = '{0, 0, 8'h00, 1, 1, 0, 0, 0};
        tbl[5] = '{1, 0, 8'h00, 1, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].st, tbl[i].v, tbl[i].d, 4'd0);
            check("tbl_rdy",  32'(if1.ld_ready),    32'(tbl[i].e_rdy));
            check("tbl_busy", 32'(if1.busy),        32'(tbl[i].e_busy));
            check("tbl_ld",   32'(if1.loaded),      32'(tbl[i].e_ld));
            check("tbl_err",  32'(if1.error),       32'(tbl[i].e_err));
            check("tbl_nrst", 32'(if1.cpu_n_reset), 32'(tbl[i].e_nrst));
        end

        // Test 2: bad checksum, then restart from ERR.
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        stream(8'h0A);
        check("t2_error", 32'(if1.error), 32'(1));
        check("t2_nrst",  32'(if1.cpu_n_reset), 32'(0));
        check("t2_rdy",   32'(if1.ld_ready), 32'(0));
        cyc(1'b0, 1'b1, 8'h09, 4'd0);
        check("t2_err_hold", 32'(if1.error), 32'(1));
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        check("t2_restart_busy", 32'(if1.busy), 32'(1));
        check("t2_restart_err",  32'(if1.error), 32'(0));

        // Test 3: ld_valid toggling every cycle.
        ck = 8'h00;
        for (int i = 0; i < 16; i++) begin
            img[i] = 8'($urandom_range(1, 255));
            ck     = ck + img[i];
        end
        k = 0;
        cyc_used = 0;
        for (int i = 0; i < 40 && k < 17; i++) begin
            v = (i % 2 == 0);
            d = (k < 16) ? img[k] : ck;
            if (v && if1.ld_ready) k++;
            cyc(1'b0, v, d, 4'(i));
            cyc_used = i;
        end
        check("t3_transfers", 32'(k), 32'(17));
        check("t3_cycles",    32'(cyc_used), 32'(32));
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        check("t3_loaded", 32'(if1.loaded), 32'(1));
        for (int a = 0; a < 16; a++) begin
            cyc(1'b0, 1'b0, 8'h00, 4'(a));
            check("t3_mem", 32'(if1.instr), 32'(img[a]));
        end

        // Test 4: ld_start collides with the 6th byte.
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h11 + i), 4'd0);
        cyc(1'b1, 1'b1, 8'h16, 4'd5);
        check("t4_drop_mem5", 32'(if1.instr), 32'(img[5]));
        check("t4_drop_rdy",  32'(if1.ld_ready), 32'(1));
        cyc(1'b0, 1'b1, 8'hAA, 4'd0);
        check("t4_wp0", 32'(if1.instr), 32'(8'hAA));
        for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, 8'hAA, 4'd1);
        cyc(1'b0, 1'b1, 8'hA0, 4'd0);
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        check("t4_loaded", 32'(if1.loaded), 32'(1));
        for (int a = 0; a < 16; a++) begin
            cyc(1'b0, 1'b0, 8'h00, 4'(a));
            check("t4_mem_aa", 32'(if1.instr), 32'(8'hAA));
        end

        // Test 5: reset after 8 bytes.
        cyc(1'b1, 1'b0, 8'h00, 4'd3);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'(8'h31 + i), 4'd3);
        check("t5_pre_instr", 32'(if1.instr), 32'(8'h34));
        do_reset();
        check("t5_instr3", 32'(if1.instr), 32'(0));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'h55, 4'd3);
            check("t5_idle_rdy", 32'(if1.ld_ready), 32'(0));
        end
        cyc(1'b1, 1'b0, 8'h00, 4'd3);
        check("t5_start_rdy", 32'(if1.ld_ready), 32'(1));

        // Test 6: no-checksum instance.
        if0.ld_start = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        if0.ld_start = 1'b0;
        check("t6_rdy", 32'(if0.ld_ready), 32'(1));
        if0.ld_valid = 1'b1;
        if0.ld_data  = 8'h00;
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 8'h00, 4'd0);
        check("t6_e1_rdy",    32'(if0.ld_ready), 32'(0));
        check("t6_e1_busy",   32'(if0.busy), 32'(1));
        check("t6_e1_loaded", 32'(if0.loaded), 32'(0));
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        check("t6_e2_loaded", 32'(if0.loaded), 32'(0));
        check("t6_e2_rdy",    32'(if0.ld_ready), 32'(0));
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        check("t6_e3_loaded", 32'(if0.loaded), 32'(1));
        check("t6_e3_nrst",   32'(if0.cpu_n_reset), 32'(1));
        cyc(1'b0, 1'b0, 8'h00, 4'd0);
        check("t6_run_rdy",   32'(if0.ld_ready), 32'(0));
        check("t6_run_err",   32'(if0.error), 32'(0));
        check("t6_instr",     32'(if0.instr), 32'(0));
        if0.ld_valid = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            st = ($urandom_range(0, 40) == 0);
            v  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (m_phase == P_AWAIT && $urandom_range(0, 1) == 1) d = m_sum;
            if ($urandom_range(0, 500) == 0) do_reset();
            else cyc(st, v, d, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
